// File: rtl/dlp_store_fifo.sv
// Display-list store: packs BYTES-wide beats into 128-bit entries, queues DEPTH of them, decodes the head.
// Optional text/glyph destination datapath is compiled in with macro DLP_TEXT_EN.
module dlp_store_fifo #(
    parameter  int BYTES = 4,
    parameter  int DEPTH = 4,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic               hb_clk,
    input  logic               hb_rstn,
    input  logic               dlp_rstn_mc,
    input  logic               dlp_wreg_pop,
    input  logic [BYTES*8-1:0] dlp_data,
    input  logic               text,
    input  logic               dlf,
    input  logic               ent_ready,
    input  logic               char_select,
    output logic               ent_valid,
    output logic [127:0]       ent_data,
    output logic               ent_text,
    output logic [1:0]         list_format,
    output logic [1:0]         wcount,
    output logic               wvs,
    output logic [6:0]         aad,
    output logic [6:0]         bad,
    output logic [6:0]         cad,
    output logic               dlp_full,
    output logic [LVL_W-1:0]   dlp_level,
    output logic               dlp_ovf,
    output logic [31:0]        curr_sorg,
    output logic [15:0]        dest_x,
    output logic [15:0]        dest_y
);

    localparam int BEATS = 16 / BYTES;
    localparam int BW    = BYTES * 8;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(DEPTH);
    localparam logic [1:0] LF_REG3 = 2'b00;
    localparam logic [1:0] LF_REG4 = 2'b01;
    localparam logic [1:0] LF_DMA  = 2'b10;
    localparam logic [1:0] LF_TEXT = 2'b11;

    logic [127:0]     r_mem [DEPTH];
    logic             r_mem_text [DEPTH];
    logic [127:0]     r_asm;
    logic [CNT_W-1:0] r_beat;
    logic             r_text_lat;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_count;
    logic             r_ovf;

    logic [127:0]     w_asm_next;
    logic [127:0]     w_head;
    logic             w_full;
    logic             w_pop;
    logic             w_accept;
    logic             w_drop;
    logic             w_last;
    logic             w_push;
    logic             w_text_beat;

    assign w_full      = (r_count == FULL_LVL);
    assign ent_valid   = (r_count != '0);
    assign w_pop       = ent_valid & ent_ready;
    // A full FIFO still takes a beat when the head leaves in the same cycle.
    assign w_accept    = dlp_wreg_pop & (~w_full | w_pop);
    assign w_drop      = dlp_wreg_pop & w_full & ~w_pop;
    assign w_last      = (r_beat == LAST_BEAT);
    assign w_push      = w_accept & w_last;
    assign w_text_beat = (r_beat == '0) ? text : r_text_lat;

    genvar gi;
    generate
        for (gi = 0; gi < BEATS; gi++) begin : g_slot
            assign w_asm_next[gi*BW +: BW] = (r_beat == CNT_W'(gi)) ? dlp_data : r_asm[gi*BW +: BW];
        end
    endgenerate

    always_ff @(posedge hb_clk or negedge hb_rstn) begin
        if (!hb_rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i]      <= '0;
                r_mem_text[i] <= 1'b0;
            end
            r_asm      <= '0;
            r_beat     <= '0;
            r_text_lat <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
        end else if (dlp_rstn_mc) begin
            r_beat   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_asm  <= w_asm_next;
                r_beat <= w_last ? '0 : r_beat + CNT_W'(1);
                if (r_beat == '0) begin
                    r_text_lat <= text;
                end
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
            if (w_push) begin
                r_mem[r_wr_ptr]      <= w_asm_next;
                r_mem_text[r_wr_ptr] <= w_text_beat;
                r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + LVL_W'(1);
                2'b01:   r_count <= r_count - LVL_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head    = r_mem[r_rd_ptr];
    assign ent_data  = w_head;
    assign ent_text  = r_mem_text[r_rd_ptr];
    assign dlp_full  = w_full;
    assign dlp_level = r_count;
    assign dlp_ovf   = r_ovf;

    always_comb begin
        list_format = LF_REG3;
        if (dlf) begin
            list_format = LF_REG4;
        end else begin
            case (w_head[25:24])
                2'b00:   list_format = LF_REG3;
                2'b01:   list_format = LF_DMA;
                default: list_format = LF_TEXT;
            endcase
        end
    end

    assign wcount = w_head[27:26];
    assign wvs    = w_head[31];
    assign aad    = {w_head[28], w_head[7:2]};
    assign bad    = {w_head[29], w_head[15:10]};
    assign cad    = {w_head[30], w_head[23:18]};

`ifdef DLP_TEXT_EN
    logic [63:0] r_dest;
    logic [63:0] w_half;
    logic [31:0] w_dest_g;
    logic        w_unused_fields;

    // A header (non-glyph) entry in TEXT format carries both glyph destinations.
    always_ff @(posedge hb_clk or negedge hb_rstn) begin
        if (!hb_rstn) begin
            r_dest <= '0;
        end else if (dlp_rstn_mc) begin
            r_dest <= '0;
        end else if (w_pop && !ent_text && (list_format == LF_TEXT)) begin
            r_dest <= {w_head[127:96], w_head[63:32]};
        end
    end

    assign w_half          = char_select ? w_head[127:64] : w_head[63:0];
    assign w_dest_g        = char_select ? r_dest[63:32] : r_dest[31:0];
    assign w_unused_fields = ^w_half[47:25];
    assign curr_sorg       = {7'h0, w_half[24:0]};
    assign dest_x          = w_dest_g[31:16] + {{8{w_half[63]}}, w_half[63:56]};
    assign dest_y          = w_dest_g[15:0] - {{8{w_half[55]}}, w_half[55:48]};
`else
    logic w_unused_cs;

    assign w_unused_cs = char_select;
    assign curr_sorg   = '0;
    assign dest_x      = '0;
    assign dest_y      = '0;
`endif

endmodule

// File: tb/tb_dlp_store_fifo.sv
// Directed bench for dlp_store_fifo: table-driven queue vectors (BYTES=4) plus hand sequences
// for header decode, glyph destinations and a BYTES=16 full-FIFO push-with-pop corner.
module tb_dlp_store_fifo;

    logic hb_clk = 1'b0;
    always #5 hb_clk = ~hb_clk;

    logic         hb_rstn, text, dlf, char_select;
    // BYTES=4 instance
    logic         flush, pop, ready;
    logic [31:0]  data;
    logic         ent_valid, ent_text, wvs, dlp_full, dlp_ovf;
    logic [127:0] ent_data;
    logic [1:0]   list_format, wcount;
    logic [6:0]   aad, bad, cad;
    logic [2:0]   dlp_level;
    logic [31:0]  curr_sorg;
    logic [15:0]  dest_x, dest_y;
    // BYTES=16 instance
    logic         flush16, pop16, ready16;
    logic [127:0] data16;
    logic         ent_valid16, ent_text16, wvs16, dlp_full16, dlp_ovf16;
    logic [127:0] ent_data16;
    logic [1:0]   list_format16, wcount16;
    logic [6:0]   aad16, bad16, cad16;
    logic [2:0]   dlp_level16;
    logic [31:0]  curr_sorg16;
    logic [15:0]  dest_x16, dest_y16;

    dlp_store_fifo #(.BYTES(4), .DEPTH(4)) u_dut (
        .hb_clk(hb_clk), .hb_rstn(hb_rstn), .dlp_rstn_mc(flush), .dlp_wreg_pop(pop),
        .dlp_data(data), .text(text), .dlf(dlf), .ent_ready(ready), .char_select(char_select),
        .ent_valid(ent_valid), .ent_data(ent_data), .ent_text(ent_text), .list_format(list_format),
        .wcount(wcount), .wvs(wvs), .aad(aad), .bad(bad), .cad(cad), .dlp_full(dlp_full),
        .dlp_level(dlp_level), .dlp_ovf(dlp_ovf), .curr_sorg(curr_sorg), .dest_x(dest_x),
        .dest_y(dest_y)
    );

    dlp_store_fifo #(.BYTES(16), .DEPTH(4)) u_dut16 (
        .hb_clk(hb_clk), .hb_rstn(hb_rstn), .dlp_rstn_mc(flush16), .dlp_wreg_pop(pop16),
        .dlp_data(data16), .text(text), .dlf(dlf), .ent_ready(ready16), .char_select(char_select),
        .ent_valid(ent_valid16), .ent_data(ent_data16), .ent_text(ent_text16),
        .list_format(list_format16), .wcount(wcount16), .wvs(wvs16), .aad(aad16), .bad(bad16),
        .cad(cad16), .dlp_full(dlp_full16), .dlp_level(dlp_level16), .dlp_ovf(dlp_ovf16),
        .curr_sorg(curr_sorg16), .dest_x(dest_x16), .dest_y(dest_y16)
    );

    typedef struct {
        logic         beat;
        logic [31:0]  data;
        logic         ready;
        logic         flush;
        logic         exp_valid;
        logic [2:0]   exp_level;
        logic         exp_ovf;
        logic         chk_data;
        logic [127:0] exp_data;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs [NV];
    int   n_err = 0;
    int   n_chk = 0;

    localparam logic [127:0] ENT_A = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] ENT_B = 128'hB0000003_B0000002_B0000001_B0000000;
    localparam logic [127:0] ENT_N = 128'h88888888_77777777_66666666_55555555;

    function automatic vec_t mk(input logic b, input logic [31:0] d, input logic r, input logic f,
                                input logic ev, input logic [2:0] el, input logic eo,
                                input logic cd, input logic [127:0] ed);
        vec_t v;
        v.beat = b; v.data = d; v.ready = r; v.flush = f;
        v.exp_valid = ev; v.exp_level = el; v.exp_ovf = eo; v.chk_data = cd; v.exp_data = ed;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge hb_clk);
        #1;
    endtask

    task automatic beat4(input logic [31:0] d, input logic t);
        pop  = 1'b1;
        data = d;
        text = t;
        tick();
        pop  = 1'b0;
        text = 1'b0;
    endtask

    task automatic beat16(input logic [127:0] d, input logic r);
        pop16   = 1'b1;
        data16  = d;
        ready16 = r;
        tick();
        pop16   = 1'b0;
        ready16 = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_sorg0, exp_sorg1;
        logic [15:0] exp_x0, exp_y0, exp_x1, exp_y1;

        hb_rstn = 1'b1; text = 1'b0; dlf = 1'b0; char_select = 1'b0;
        flush = 1'b0; pop = 1'b0; ready = 1'b0; data = '0;
        flush16 = 1'b0; pop16 = 1'b0; ready16 = 1'b0; data16 = '0;

        //            beat data          rdy fl  val lvl ovf chk data
        vecs[0]  = mk(1, 32'h11111111, 0, 0, 0, 0, 0, 0, '0);
        vecs[1]  = mk(1, 32'h22222222, 0, 0, 0, 0, 0, 0, '0);
        vecs[2]  = mk(1, 32'h33333333, 0, 0, 0, 0, 0, 0, '0);
        vecs[3]  = mk(1, 32'h44444444, 0, 0, 1, 1, 0, 1, ENT_A);
        vecs[4]  = mk(1, 32'hB0000000, 0, 0, 1, 1, 0, 1, ENT_A);
        vecs[5]  = mk(1, 32'hB0000001, 0, 0, 1, 1, 0, 1, ENT_A);
        vecs[6]  = mk(1, 32'hB0000002, 0, 0, 1, 1, 0, 1, ENT_A);
        vecs[7]  = mk(1, 32'hB0000003, 0, 0, 1, 2, 0, 1, ENT_A);
        vecs[8]  = mk(1, 32'hC0000000, 0, 0, 1, 2, 0, 1, ENT_A);
        vecs[9]  = mk(1, 32'hC0000001, 0, 0, 1, 2, 0, 1, ENT_A);
        vecs[10] = mk(1, 32'hC0000002, 0, 0, 1, 2, 0, 1, ENT_A);
        vecs[11] = mk(1, 32'hC0000003, 0, 0, 1, 3, 0, 1, ENT_A);
        vecs[12] = mk(1, 32'hD0000000, 0, 0, 1, 3, 0, 1, ENT_A);
        vecs[13] = mk(1, 32'hD0000001, 0, 0, 1, 3, 0, 1, ENT_A);
        vecs[14] = mk(1, 32'hD0000002, 0, 0, 1, 3, 0, 1, ENT_A);
        vecs[15] = mk(1, 32'hD0000003, 0, 0, 1, 4, 0, 1, ENT_A);
        vecs[16] = mk(1, 32'hE0000000, 0, 0, 1, 4, 1, 1, ENT_A);
        vecs[17] = mk(0, 32'h00000000, 1, 0, 1, 3, 1, 1, ENT_B);
        vecs[18] = mk(1, 32'hF0000000, 0, 0, 1, 3, 1, 1, ENT_B);
        vecs[19] = mk(1, 32'hF0000001, 0, 0, 1, 3, 1, 1, ENT_B);
        vecs[20] = mk(0, 32'h00000000, 0, 1, 0, 0, 0, 0, '0);
        vecs[21] = mk(1, 32'h55555555, 0, 0, 0, 0, 0, 0, '0);
        vecs[22] = mk(1, 32'h66666666, 0, 0, 0, 0, 0, 0, '0);
        vecs[23] = mk(1, 32'h77777777, 0, 0, 0, 0, 0, 0, '0);
        vecs[24] = mk(1, 32'h88888888, 0, 0, 1, 1, 0, 1, ENT_N);
        vecs[25] = mk(0, 32'h00000000, 1, 0, 0, 0, 0, 0, '0);

        // Asynchronous reset: outputs cleared before any clock edge releases it
        #2 hb_rstn = 1'b0;
        #10;
        chk("rst_valid", 128'(ent_valid), 128'(0));
        chk("rst_level", 128'(dlp_level), 128'(0));
        chk("rst_ovf",   128'(dlp_ovf),   128'(0));
        chk("rst_full",  128'(dlp_full),  128'(0));
        chk("rst_data",  ent_data,        128'(0));
        chk("rst_level16", 128'(dlp_level16), 128'(0));
        @(posedge hb_clk);
        #1 hb_rstn = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) begin
            pop   = vecs[i].beat;
            data  = vecs[i].data;
            ready = vecs[i].ready;
            flush = vecs[i].flush;
            tick();
            pop = 1'b0; ready = 1'b0; flush = 1'b0;
            $display("vec %0d beat=%0b data=%h ready=%0b flush=%0b -> valid=%0b level=%0d full=%0b ovf=%0b head=%h",
                     i, vecs[i].beat, vecs[i].data, vecs[i].ready, vecs[i].flush,
                     ent_valid, dlp_level, dlp_full, dlp_ovf, ent_data);
            chk($sformatf("v%0d_valid", i), 128'(ent_valid), 128'(vecs[i].exp_valid));
            chk($sformatf("v%0d_level", i), 128'(dlp_level), 128'(vecs[i].exp_level));
            chk($sformatf("v%0d_full", i),  128'(dlp_full),  128'(vecs[i].exp_level == 3'd4));
            chk($sformatf("v%0d_ovf", i),   128'(dlp_ovf),   128'(vecs[i].exp_ovf));
            if (vecs[i].chk_data) begin
                chk($sformatf("v%0d_data", i), ent_data, vecs[i].exp_data);
            end
        end

        // Header entry in TEXT format: destinations 0x0010_0020 (char0) and 0x0100_0200 (char1)
        beat4(32'h9E84080C, 1'b0);
        beat4(32'h00100020, 1'b0);
        beat4(32'h00000000, 1'b0);
        beat4(32'h01000200, 1'b0);
        $display("hdr head=%h valid=%0b lf=%0b wcount=%0b wvs=%0b aad=%h bad=%h cad=%h",
                 ent_data, ent_valid, list_format, wcount, wvs, aad, bad, cad);
        chk("hdr_valid", 128'(ent_valid), 128'(1));
        chk("hdr_text",  128'(ent_text),  128'(0));
        chk("hdr_lf",    128'(list_format), 128'(2'b11));
        chk("hdr_wcount", 128'(wcount), 128'(2'b11));
        chk("hdr_wvs",   128'(wvs), 128'(1));
        chk("hdr_aad",   128'(aad), 128'(7'h43));
        chk("hdr_bad",   128'(bad), 128'(7'h02));
        chk("hdr_cad",   128'(cad), 128'(7'h21));
        dlf = 1'b1;
        #1 chk("hdr_lf_dlf", 128'(list_format), 128'(2'b01));
        dlf = 1'b0;

        // Glyph entry queued behind the header, then the header is consumed
        beat4(32'h01234567, 1'b1);
        beat4(32'hFE030000, 1'b0);
        beat4(32'h00ABCDEF, 1'b0);
        beat4(32'h05FF0000, 1'b0);
        chk("gly_level2", 128'(dlp_level), 128'(2));
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("gly_level1", 128'(dlp_level), 128'(1));
        chk("gly_text",   128'(ent_text),  128'(1));

`ifdef DLP_TEXT_EN
        exp_sorg0 = 32'h01234567; exp_x0 = 16'h000E; exp_y0 = 16'h001D;
        exp_sorg1 = 32'h00ABCDEF; exp_x1 = 16'h0105; exp_y1 = 16'h0201;
`else
        exp_sorg0 = '0; exp_x0 = '0; exp_y0 = '0;
        exp_sorg1 = '0; exp_x1 = '0; exp_y1 = '0;
`endif
        char_select = 1'b0;
        #1;
        $display("glyph g=0 sorg=%h dest_x=%h dest_y=%h", curr_sorg, dest_x, dest_y);
        chk("g0_sorg", 128'(curr_sorg), 128'(exp_sorg0));
        chk("g0_dx",   128'(dest_x),    128'(exp_x0));
        chk("g0_dy",   128'(dest_y),    128'(exp_y0));
        char_select = 1'b1;
        #1;
        $display("glyph g=1 sorg=%h dest_x=%h dest_y=%h", curr_sorg, dest_x, dest_y);
        chk("g1_sorg", 128'(curr_sorg), 128'(exp_sorg1));
        chk("g1_dx",   128'(dest_x),    128'(exp_x1));
        chk("g1_dy",   128'(dest_y),    128'(exp_y1));
        char_select = 1'b0;

        // BYTES=16: every beat is an entry; push with pop while full is accepted
        beat16({4{32'h00000001}}, 1'b0);
        $display("b16 push1 valid=%0b level=%0d head=%h", ent_valid16, dlp_level16, ent_data16);
        chk("b16_valid", 128'(ent_valid16), 128'(1));
        chk("b16_lvl1",  128'(dlp_level16), 128'(1));
        chk("b16_head1", ent_data16, {4{32'h00000001}});
        beat16({4{32'h00000002}}, 1'b0);
        beat16({4{32'h00000003}}, 1'b0);
        beat16({4{32'h00000004}}, 1'b0);
        $display("b16 push4 level=%0d full=%0b", dlp_level16, dlp_full16);
        chk("b16_full",  128'(dlp_full16),  128'(1));
        chk("b16_lvl4",  128'(dlp_level16), 128'(4));
        beat16({4{32'h00000005}}, 1'b1);
        $display("b16 push+pop level=%0d ovf=%0b head=%h", dlp_level16, dlp_ovf16, ent_data16);
        chk("b16_pp_lvl",  128'(dlp_level16), 128'(4));
        chk("b16_pp_ovf",  128'(dlp_ovf16),   128'(0));
        chk("b16_pp_head", ent_data16, {4{32'h00000002}});
        beat16({4{32'h00000006}}, 1'b0);
        $display("b16 drop level=%0d ovf=%0b", dlp_level16, dlp_ovf16);
        chk("b16_drop_ovf", 128'(dlp_ovf16),   128'(1));
        chk("b16_drop_lvl", 128'(dlp_level16), 128'(4));
        chk("b16_drop_head", ent_data16, {4{32'h00000002}});

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
